m_seg_scanner: RTL and testbench

Time-multiplexed seven-segment display driver for a multi-digit common-anode display. Consumes the packed BCD bus produced by the BCD counter stage, holds it in tear-free shadow/active registers, and scans one digit at a time with a blanking gap between digits to suppress ghosting. Sits between the counter and the board's segment and digit-select pins.

---
 rtl/m_seg_scanner_pkg.sv | 25 ++
 rtl/m_seg_scanner_seven_segment.sv | 36 +++
 rtl/m_seg_scanner.sv | 188 ++++++++++++++++++
 tb/tb_m_seg_scanner.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/m_seg_scanner_pkg.sv
// -----------------------------------------------------------------------------
// m_seg_scanner_pkg
// Shared definitions for the seven-segment scanner: FSM state encoding,
// the all-segments-off pattern, default parameter values, and a small
// elaboration-time helper.
// -----------------------------------------------------------------------------
package m_seg_scanner_pkg;

    typedef enum logic {
        ST_ON    = 1'b0,   // current digit is lit
        ST_BLANK = 1'b1    // all digits dark between slots
    } state_e;

    // Active-low segments, so all ones is fully dark (decimal point included).
    localparam logic [7:0] SEG_OFF = 8'hFF;

    localparam int DIGITS_DEF    = 4;
    localparam int SCAN_DIV_DEF  = 50000;
    localparam int BLANK_CYC_DEF = 64;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/m_seg_scanner_seven_segment.sv
// -----------------------------------------------------------------------------
// m_seven_segment
// Hex nibble to common-anode (active-low) seven-segment pattern.
// Bit 7 is the decimal point and is always off.
//
// Ports:
//   nibble_i  in  4  value to display (0..F, shown as hex)
//   seg_n_o   out 8  active-low segments {dp, g, f, e, d, c, b, a}
// -----------------------------------------------------------------------------
module m_seven_segment (
    input  logic [3:0] nibble_i,
    output logic [7:0] seg_n_o
);

    always_comb begin
        case (nibble_i)
            4'h0:    seg_n_o = 8'hC0;
            4'h1:    seg_n_o = 8'hF9;
            4'h2:    seg_n_o = 8'hA4;
            4'h3:    seg_n_o = 8'hB0;
            4'h4:    seg_n_o = 8'h99;
            4'h5:    seg_n_o = 8'h92;
            4'h6:    seg_n_o = 8'h82;
            4'h7:    seg_n_o = 8'hF8;
            4'h8:    seg_n_o = 8'h80;
            4'h9:    seg_n_o = 8'h98;
            4'hA:    seg_n_o = 8'h88;
            4'hB:    seg_n_o = 8'h83;
            4'hC:    seg_n_o = 8'hA7;
            4'hD:    seg_n_o = 8'hA1;
            4'hE:    seg_n_o = 8'h86;
            default: seg_n_o = 8'h8E;
        endcase
    end

endmodule

// File: rtl/m_seg_scanner.sv
// -----------------------------------------------------------------------------
// m_seg_scanner
// Time-multiplexed driver for a multi-digit common-anode seven-segment display.
// A captured BCD value is parked in a pending register and only moved into the
// displayed (active) register at the end of a full scan, so a frame never
// shows a mix of old and new digits. Each digit is lit for SCAN_DIV clocks and
// followed by BLANK_CYC all-dark clocks to suppress ghosting.
//
// Optional build macro:
//   SEG_SCAN_LZB_EN  leading-zero blanking; digits above 0 whose value and all
//                    higher digits are zero stay dark during their slot.
//
// Ports:
//   clk      in   1          system clock, rising edge
//   n_reset  in   1          asynchronous active-low reset
//   bcd_in   in   4*DIGITS   packed value, bits [3:0] are digit 0
//   load     in   1          single-cycle capture strobe for bcd_in
//   busy     out  1          a captured value is waiting to be displayed
//   seg_n    out  8          active-low segments, bit 7 = decimal point (off)
//   dig_n    out  DIGITS     active-low one-hot digit select
//   frame    out  1          pulse in the first lit cycle of digit 0
// -----------------------------------------------------------------------------
module m_seg_scanner
    import m_seg_scanner_pkg::*;
#(
    parameter int DIGITS    = DIGITS_DEF,
    parameter int SCAN_DIV  = SCAN_DIV_DEF,
    parameter int BLANK_CYC = BLANK_CYC_DEF
) (
    input  logic                  clk,
    input  logic                  n_reset,
    input  logic [4*DIGITS-1:0]   bcd_in,
    input  logic                  load,
    output logic                  busy,
    output logic [7:0]            seg_n,
    output logic [DIGITS-1:0]     dig_n,
    output logic                  frame
);

    localparam int CNT_W = $clog2(max_int(SCAN_DIV, BLANK_CYC));
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CNT_W-1:0] SCAN_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DIGITS - 1);

    state_e                state_q,   state_d;
    logic [IDX_W-1:0]      idx_q,     idx_d;
    logic [CNT_W-1:0]      phase_q,   phase_d;
    logic [4*DIGITS-1:0]   pending_q, pending_d;
    logic [4*DIGITS-1:0]   active_q,  active_d;
    logic                  busy_q,    busy_d;
    logic [7:0]            seg_n_q,   seg_n_d;
    logic [DIGITS-1:0]     dig_n_q,   dig_n_d;
    logic                  frame_q,   frame_d;

    logic                  commit;
    logic [4*DIGITS-1:0]   active_shr;
    logic [3:0]            nibble;
    logic [7:0]            seg_dec;
    logic                  lzb_dark;

    // -------------------------------------------------------------------------
    // Scan sequencing. The last BLANK cycle of the highest digit is the frame
    // boundary, where the pending value is committed.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can
        // leave it unassigned and infer a latch.
        state_d = state_q;
        idx_d   = idx_q;
        phase_d = phase_q + 1'b1;
        commit  = 1'b0;

        case (state_q)
            ST_ON: begin
                if (phase_q == SCAN_LAST) begin
                    state_d = ST_BLANK;
                    phase_d = '0;
                end
            end
            ST_BLANK: begin
                if (phase_q == BLANK_LAST) begin
                    state_d = ST_ON;
                    phase_d = '0;
                    if (idx_q == IDX_LAST) begin
                        idx_d  = '0;
                        commit = 1'b1;
                    end else begin
                        idx_d  = idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_BLANK;
                phase_d = '0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Capture and commit. A load coinciding with the commit goes straight to
    // the display and never raises busy.
    // -------------------------------------------------------------------------
    always_comb begin
        pending_d = load ? bcd_in : pending_q;
        active_d  = active_q;
        busy_d    = busy_q;

        if (commit) begin
            busy_d = 1'b0;
            if (load) begin
                active_d = bcd_in;
            end else if (busy_q) begin
                active_d = pending_q;
            end
        end else if (load) begin
            busy_d = 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Output generation from next-state values so the registered pins line up
    // with the FSM state they describe.
    // -------------------------------------------------------------------------
    assign active_shr = active_d >> {idx_d, 2'b00};
    assign nibble     = active_shr[3:0];

`ifdef SEG_SCAN_LZB_EN
    // Dark when this digit and everything above it are zero; digit 0 stays lit.
    assign lzb_dark = (idx_d != '0) && (active_shr == '0);
`else
    assign lzb_dark = 1'b0;
`endif

    m_seven_segment u_decoder (
        .nibble_i (nibble),
        .seg_n_o  (seg_dec)
    );

    always_comb begin
        seg_n_d = SEG_OFF;
        dig_n_d = '1;
        frame_d = (state_d == ST_ON) && (idx_d == '0) && (phase_d == '0);

        if ((state_d == ST_ON) && !lzb_dark) begin
            seg_n_d = seg_dec;
            dig_n_d = ~(DIGITS'(1) << idx_d);
        end
    end

    // -------------------------------------------------------------------------
    // State and output registers.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q   <= ST_BLANK;
            idx_q     <= IDX_LAST;
            phase_q   <= '0;
            // NOTE: pending/active are plain registers, not RAM, so they are
            // reset; a mid-scan reset must discard any queued value.
            pending_q <= '0;
            active_q  <= '0;
            busy_q    <= 1'b0;
            seg_n_q   <= SEG_OFF;
            dig_n_q   <= '1;
            frame_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling the
            // pre-edge values, independent of statement order.
            state_q   <= state_d;
            idx_q     <= idx_d;
            phase_q   <= phase_d;
            pending_q <= pending_d;
            active_q  <= active_d;
            busy_q    <= busy_d;
            seg_n_q   <= seg_n_d;
            dig_n_q   <= dig_n_d;
            frame_q   <= frame_d;
        end
    end

    assign busy  = busy_q;
    assign seg_n = seg_n_q;
    assign dig_n = dig_n_q;
    assign frame = frame_q;

endmodule

// File: tb/tb_m_seg_scanner.sv
// -----------------------------------------------------------------------------
// tb_m_seg_scanner
// Self-checking bench for m_seg_scanner with DIGITS=2, SCAN_DIV=4, BLANK_CYC=2.
// The reference model tracks only the count of clocks since reset release and
// the displayed/pending values; expected pins are derived from the position of
// that count within the frame.
// -----------------------------------------------------------------------------
module tb_m_seg_scanner;

    localparam int DIGITS    = 2;
    localparam int SCAN_DIV  = 4;
    localparam int BLANK_CYC = 2;
    localparam int SLOT      = SCAN_DIV + BLANK_CYC;
    localparam int PERIOD    = DIGITS * SLOT;

    logic                clk = 1'b0;
    logic                n_reset = 1'b0;
    logic [4*DIGITS-1:0] bcd_in = '0;
    logic                load = 1'b0;
    logic                busy;
    logic [7:0]          seg_n;
    logic [DIGITS-1:0]   dig_n;
    logic                frame;

    m_seg_scanner #(
        .DIGITS    (DIGITS),
        .SCAN_DIV  (SCAN_DIV),
        .BLANK_CYC (BLANK_CYC)
    ) dut (
        .clk     (clk),
        .n_reset (n_reset),
        .bcd_in  (bcd_in),
        .load    (load),
        .busy    (busy),
        .seg_n   (seg_n),
        .dig_n   (dig_n),
        .frame   (frame)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state.
    int         cyc;         // rising edges since reset release
    logic [7:0] m_active;
    logic [7:0] m_pending;
    logic       m_busy;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [7:0] hex_seg(input int v);
        logic [7:0] tbl [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h98, 8'h88, 8'h83, 8'hA7, 8'hA1, 8'h86, 8'h8E};
        return tbl[v & 15];
    endfunction

    task automatic model_reset();
        cyc       = 0;
        m_active  = '0;
        m_pending = '0;
        m_busy    = 1'b0;
    endtask

    // Applies one rising edge to the model, with the load inputs seen at it.
    task automatic model_edge(input logic ld, input logic [7:0] val);
        int p = cyc % PERIOD;
        if (p == BLANK_CYC - 1) begin
            if (ld)          m_active = val;
            else if (m_busy) m_active = m_pending;
            if (ld)          m_pending = val;
            m_busy = 1'b0;
        end else if (ld) begin
            m_pending = val;
            m_busy    = 1'b1;
        end
        cyc++;
    endtask

    task automatic check_outputs();
        int         p = cyc % PERIOD;
        int         k = -1;
        int         hi;
        logic       lit;
        logic [7:0] exp_seg = 8'hFF;
        logic [1:0] exp_dig = 2'b11;

        if (p >= BLANK_CYC && ((p - BLANK_CYC) % SLOT) < SCAN_DIV)
            k = (p - BLANK_CYC) / SLOT;

        if (k >= 0) begin
            hi  = int'(m_active) >> (4 * k);
            lit = 1'b1;
`ifdef SEG_SCAN_LZB_EN
            if (k > 0 && hi == 0) lit = 1'b0;
`endif
            if (lit) begin
                exp_seg    = hex_seg(hi);
                exp_dig[k] = 1'b0;
            end
        end

        check("seg_n", 32'(seg_n), 32'(exp_seg));
        check("dig_n", 32'(dig_n), 32'(exp_dig));
        check("frame", 32'(frame), 32'(p == BLANK_CYC));
        check("busy",  32'(busy),  32'(m_busy));
    endtask

    // One clock: drive inputs while clk is low, update the model at the rising
    // edge, then compare on the falling edge.
    task automatic step(input logic ld, input logic [7:0] val);
        load   = ld;
        bcd_in = val;
        @(posedge clk);
        model_edge(ld, val);
        @(negedge clk);
        load   = 1'b0;
        bcd_in = '0;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00);
    endtask

    task automatic run_to(input int p_target);
        while ((cyc % PERIOD) != p_target) step(1'b0, 8'h00);
    endtask

    // Asynchronous reset while clk is low: outputs must blank before any edge.
    task automatic reset_mid_scan();
        #2 n_reset = 1'b0;
        model_reset();
        #1 check_outputs();
        repeat (2) @(negedge clk);
        check_outputs();
        n_reset = 1'b1;
        check_outputs();
    endtask

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        check_outputs();
        n_reset = 1'b1;
        check_outputs();

        // First frame from reset: two blank clocks, digit 0 with frame pulse.
        idx_first: idle(PERIOD + 2);

        // Mid-frame load waits for the next digit 0.
        run_to(4);
        step(1'b1, 8'h59);
        idle(2 * PERIOD + 2);

        // Load exactly on the commit cycle goes straight to the display.
        run_to(BLANK_CYC - 1);
        step(1'b1, 8'h37);
        idle(PERIOD + 1);

        // Back-to-back loads: last value wins.
        run_to(4);
        step(1'b1, 8'h11);
        step(1'b0, 8'h00);
        step(1'b1, 8'h22);
        idle(2 * PERIOD + 2);

        // Reset during digit 1 with a value pending.
        run_to(BLANK_CYC + SLOT);
        step(1'b1, 8'h42);
        reset_mid_scan();
        idle(PERIOD + 4);

        // Leading zero in the upper digit, then a non-BCD nibble.
        run_to(4);
        step(1'b1, 8'h07);
        idle(2 * PERIOD + 2);
        run_to(6);
        step(1'b1, 8'h0A);
        idle(2 * PERIOD + 2);

        // Randomized loads, including some landing on the commit cycle.
        for (int i = 0; i < 400; i++) begin
            if (i == 200) reset_mid_scan();
            step(($urandom_range(0, 4) == 0), 8'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
